// File: rtl/multicycle_shift_unit.sv
// Iterative barrel shifter: SLL/SRL/SRA/ROR/ROL on a WIDTH-bit operand.
// Each clock in SHIFT resolves one binary stage of the effective amount.
// Ports:
//   CLK, RESET           clock (rising edge), async active-high reset
//   IN_VALID/IN_READY    request handshake (DATA, SHAMT, MODE)
//   OUT_VALID/OUT_READY  result handshake (RESULT, CARRY, ZERO)
//   MODE                 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others pass-through
module multicycle_shift_unit #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned SHAMT_W = $clog2(WIDTH) + 1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               IN_VALID,
   output logic               IN_READY,
   input  logic [WIDTH-1:0]   DATA,
   input  logic [SHAMT_W-1:0] SHAMT,
   input  logic [2:0]         MODE,
   output logic               OUT_VALID,
   input  logic               OUT_READY,
   output logic [WIDTH-1:0]   RESULT,
   output logic               CARRY,
   output logic               ZERO
);

   localparam int unsigned L  = $clog2(WIDTH);
   localparam int unsigned KW = (L > 1) ? $clog2(L) : 1;

   localparam logic [2:0] M_SLL = 3'b000;
   localparam logic [2:0] M_SRL = 3'b001;
   localparam logic [2:0] M_SRA = 3'b010;
   localparam logic [2:0] M_ROR = 3'b011;
   localparam logic [2:0] M_ROL = 3'b100;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [KW-1:0]      k_q, k_d;
   logic [L-1:0]       e_q, e_d;
   logic [2:0]         mode_q, mode_d;
   logic               sign_q, sign_d;
   logic [WIDTH-1:0]   work_q, work_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carry_q, carry_d;
   logic               zero_q, zero_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;

   // One stage: move v by 2^k in the direction selected by m.
   function automatic logic [WIDTH-1:0] apply_stage(input logic [WIDTH-1:0] v,
                                                    input logic [2:0]       m,
                                                    input logic             s,
                                                    input logic [KW-1:0]    k);
      logic [SHAMT_W-1:0] amt;
      logic [SHAMT_W-1:0] rem;
      logic [WIDTH-1:0]   ones;
      amt  = SHAMT_W'(1) << k;
      rem  = SHAMT_W'(WIDTH) - amt;
      ones = '1;
      case (m)
         M_SLL:   apply_stage = v << amt;
         M_SRL:   apply_stage = v >> amt;
         M_SRA:   apply_stage = (v >> amt) | (s ? ~(ones >> amt) : '0);
         M_ROR:   apply_stage = (v >> amt) | (v << rem);
         M_ROL:   apply_stage = (v << amt) | (v >> rem);
         default: apply_stage = v;
      endcase
   endfunction

   // Acceptance-time decode of effective amount, initial working value and carry.
   logic               is_rot;
   logic               is_shift;
   logic               big;
   logic               in_range;
   logic [SHAMT_W-1:0] idx_sll;
   logic [SHAMT_W-1:0] idx_srl;
   logic [L-1:0]       acc_e;
   logic [WIDTH-1:0]   acc_work;
   logic               acc_carry;

   always_comb begin
      is_rot    = (MODE == M_ROR) || (MODE == M_ROL);
      is_shift  = (MODE == M_SLL) || (MODE == M_SRL) || (MODE == M_SRA);
      // SHAMT never exceeds 2*WIDTH-1, so its MSB alone flags SHAMT >= WIDTH.
      big       = SHAMT[SHAMT_W-1];
      in_range  = (SHAMT != '0) && (SHAMT <= SHAMT_W'(WIDTH));
      idx_sll   = SHAMT_W'(WIDTH) - SHAMT;
      idx_srl   = SHAMT - SHAMT_W'(1);

      acc_e     = '0;
      acc_work  = DATA;
      acc_carry = 1'b0;

      if (is_rot || (is_shift && !big)) begin
         acc_e = SHAMT[L-1:0];
      end
      if (is_shift && big) begin
         acc_work = (MODE == M_SRA) ? {WIDTH{DATA[WIDTH-1]}} : '0;
      end

      // Rotate carry depends on the final result and is set on the last stage.
      case (MODE)
         M_SLL:   acc_carry = in_range ? DATA[idx_sll[L-1:0]] : 1'b0;
         M_SRL:   acc_carry = in_range ? DATA[idx_srl[L-1:0]] : 1'b0;
         M_SRA: begin
            if (in_range)
               acc_carry = DATA[idx_srl[L-1:0]];
            else if (SHAMT != '0)
               acc_carry = DATA[WIDTH-1];
         end
         default: acc_carry = 1'b0;
      endcase
   end

   // Next-state and datapath update.
   logic [WIDTH-1:0] stage_val;

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      e_d         = e_q;
      mode_d      = mode_q;
      sign_d      = sign_q;
      work_d      = work_q;
      result_d    = result_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      stage_val   = apply_stage(work_q, mode_q, sign_q, k_q);

      case (state_q)
         S_IDLE: begin
            if (IN_VALID) begin
               state_d    = S_SHIFT;
               k_d        = '0;
               e_d        = acc_e;
               mode_d     = MODE;
               sign_d     = DATA[WIDTH-1];
               work_d     = acc_work;
               carry_d    = acc_carry;
               in_ready_d = 1'b0;
            end
         end
         S_SHIFT: begin
            if (e_q[k_q]) begin
               work_d = stage_val;
            end
            k_d = k_q + KW'(1);
            if (k_q == KW'(L - 1)) begin
               state_d     = S_DONE;
               k_d         = '0;
               out_valid_d = 1'b1;
               result_d    = work_d;
               zero_d      = (work_d == '0);
               if (e_q != '0) begin
                  if (mode_q == M_ROR) carry_d = work_d[WIDTH-1];
                  if (mode_q == M_ROL) carry_d = work_d[0];
               end
            end
         end
         S_DONE: begin
            if (OUT_READY) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         e_q         <= '0;
         mode_q      <= '0;
         sign_q      <= 1'b0;
         work_q      <= '0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         e_q         <= e_d;
         mode_q      <= mode_d;
         sign_q      <= sign_d;
         work_q      <= work_d;
         result_q    <= result_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign RESULT    = result_q;
   assign CARRY     = carry_q;
   assign ZERO      = zero_q;

endmodule

// File: tb/tb_multicycle_shift_unit.sv
// Testbench for multicycle_shift_unit: directed cases at WIDTH=8 plus
// random requests at WIDTH=8 and WIDTH=32 compared with a bit-serial model.
module tb_multicycle_shift_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       iv8, ir8, ov8, or8, c8, z8;
   logic [7:0] d8, r8;
   logic [3:0] s8;
   logic [2:0] m8;

   logic        iv32, ir32, ov32, or32, c32, z32;
   logic [31:0] d32, r32;
   logic [5:0]  s32;
   logic [2:0]  m32;

   multicycle_shift_unit #(.WIDTH(8)) dut8 (
      .CLK(clk), .RESET(rst), .IN_VALID(iv8), .IN_READY(ir8), .DATA(d8), .SHAMT(s8),
      .MODE(m8), .OUT_VALID(ov8), .OUT_READY(or8), .RESULT(r8), .CARRY(c8), .ZERO(z8));

   multicycle_shift_unit #(.WIDTH(32)) dut32 (
      .CLK(clk), .RESET(rst), .IN_VALID(iv32), .IN_READY(ir32), .DATA(d32), .SHAMT(s32),
      .MODE(m32), .OUT_VALID(ov32), .OUT_READY(or32), .RESULT(r32), .CARRY(c32), .ZERO(z32));

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: apply the shift one bit at a time, n times; carry is the last bit out.
   function automatic void ref_model(input int w, input logic [63:0] data, input int n,
                                     input int mode, output logic [63:0] res, output logic cy);
      logic [63:0] mask, x, sgn;
      int e;
      mask = (64'd1 << w) - 64'd1;
      x    = data & mask;
      sgn  = {63'd0, x[w-1]};
      cy   = 1'b0;
      case (mode)
         0: for (int i = 0; i < n; i++) begin cy = x[w-1]; x = (x << 1) & mask; end
         1: for (int i = 0; i < n; i++) begin cy = x[0]; x = x >> 1; end
         2: for (int i = 0; i < n; i++) begin cy = x[0]; x = (x >> 1) | (sgn << (w - 1)); end
         3: begin
            e = n % w;
            for (int i = 0; i < e; i++) begin
               cy = x[0];
               x  = (x >> 1) | ({63'd0, cy} << (w - 1));
            end
         end
         4: begin
            e = n % w;
            for (int i = 0; i < e; i++) begin
               cy = x[w-1];
               x  = ((x << 1) & mask) | {63'd0, cy};
            end
         end
         default: ;
      endcase
      res = x;
   endfunction

   task automatic drive_in(input int w, input logic v, input logic [31:0] d, input int s,
                           input logic [2:0] m);
      if (w == 8) begin iv8 = v; d8 = d[7:0]; s8 = 4'(s); m8 = m; end
      else begin iv32 = v; d32 = d; s32 = 6'(s); m32 = m; end
   endtask

   function automatic logic get_ov(input int w);
      return (w == 8) ? ov8 : ov32;
   endfunction

   function automatic logic get_ir(input int w);
      return (w == 8) ? ir8 : ir32;
   endfunction

   task automatic start_op(input int w, input logic [31:0] d, input int s, input logic [2:0] m,
                           input string tag);
      check({tag, " in_ready"}, 64'(get_ir(w)), 64'd1);
      drive_in(w, 1'b1, d, s, m);
      @(posedge clk); #1;
      drive_in(w, 1'b0, ~d, s + 1, ~m);
   endtask

   task automatic wait_out(input int w, input string tag);
      int cyc = 0;
      while (!get_ov(w) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), (w == 8) ? 64'd3 : 64'd5);
   endtask

   task automatic check_out(input int w, input string tag, input logic [63:0] er, input logic ec);
      logic [63:0] res;
      res = (w == 8) ? {56'd0, r8} : {32'd0, r32};
      check({tag, " result"}, res, er);
      check({tag, " carry"}, 64'((w == 8) ? c8 : c32), 64'(ec));
      check({tag, " zero"}, 64'((w == 8) ? z8 : z32), 64'(er == 64'd0));
   endtask

   task automatic transfer(input int w, input string tag);
      if (w == 8) or8 = 1'b1; else or32 = 1'b1;
      @(posedge clk); #1;
      if (w == 8) or8 = 1'b0; else or32 = 1'b0;
      check({tag, " out_valid after xfer"}, 64'(get_ov(w)), 64'd0);
      check({tag, " in_ready after xfer"}, 64'(get_ir(w)), 64'd1);
   endtask

   task automatic run_op(input int w, input logic [31:0] d, input int s, input logic [2:0] m,
                         input logic [63:0] er, input logic ec, input string tag);
      start_op(w, d, s, m, tag);
      wait_out(w, tag);
      check_out(w, tag, er, ec);
      transfer(w, tag);
   endtask

   task automatic model_op(input int w, input logic [31:0] d, input int s, input logic [2:0] m,
                           input string tag);
      logic [63:0] er;
      logic        ec;
      ref_model(w, {32'd0, d}, s, int'(m), er, ec);
      run_op(w, d, s, m, er, ec, tag);
   endtask

   initial begin
      logic [31:0] rd;
      int          rs;
      logic [2:0]  rm;

      rst = 1'b1;
      iv8 = 0; d8 = 0; s8 = 0; m8 = 0; or8 = 0;
      iv32 = 0; d32 = 0; s32 = 0; m32 = 0; or32 = 0;
      #12;
      check("reset in_ready", 64'(ir8), 64'd1);
      check("reset out_valid", 64'(ov8), 64'd0);
      check("reset result", 64'(r8), 64'd0);
      check("reset carry", 64'(c8), 64'd0);
      check("reset zero", 64'(z8), 64'd0);
      check("reset32 in_ready", 64'(ir32), 64'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed WIDTH=8 cases with hand-derived results.
      run_op(8, 32'h96, 3,  3'b000, 64'hB0, 1'b0, "sll96_3");
      run_op(8, 32'h96, 2,  3'b010, 64'hE5, 1'b1, "sra96_2");
      run_op(8, 32'h96, 9,  3'b010, 64'hFF, 1'b1, "sra96_9");
      run_op(8, 32'h96, 11, 3'b011, 64'hD2, 1'b1, "ror96_11");
      run_op(8, 32'h96, 0,  3'b100, 64'h96, 1'b0, "rol96_0");
      run_op(8, 32'h5A, 5,  3'b111, 64'h5A, 1'b0, "rsvd5a");
      run_op(8, 32'h80, 8,  3'b001, 64'h00, 1'b1, "srl80_8");
      run_op(8, 32'h01, 15, 3'b000, 64'h00, 1'b0, "sll01_15");

      // Back-pressure: result held, new requests ignored while in DONE.
      start_op(8, 32'h96, 2, 3'b010, "hold");
      wait_out(8, "hold");
      check_out(8, "hold", 64'hE5, 1'b1);
      for (int i = 0; i < 5; i++) begin
         drive_in(8, 1'b1, $urandom, int'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
         @(posedge clk); #1;
         check_out(8, "hold stable", 64'hE5, 1'b1);
         check("hold in_ready", 64'(ir8), 64'd0);
         check("hold out_valid", 64'(ov8), 64'd1);
      end
      drive_in(8, 1'b0, 32'h0, 0, 3'b000);
      transfer(8, "hold");
      repeat (5) @(posedge clk);
      #1;
      check("no second accept", 64'(ov8), 64'd0);

      // Reset in the middle of SHIFT (stage counter at 1).
      start_op(8, 32'h96, 3, 3'b000, "midrst");
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("midrst out_valid", 64'(ov8), 64'd0);
      check("midrst in_ready", 64'(ir8), 64'd1);
      check("midrst result", 64'(r8), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check("midrst no stale", 64'(ov8), 64'd0);
      run_op(8, 32'h01, 1, 3'b000, 64'h02, 1'b0, "post_rst");

      // WIDTH=32 repeats of the directed patterns, against the model.
      model_op(32, 32'h9600_0096, 3,  3'b000, "w32 sll");
      model_op(32, 32'h9600_0096, 2,  3'b010, "w32 sra");
      model_op(32, 32'h9600_0096, 33, 3'b010, "w32 sra big");
      model_op(32, 32'h9600_0096, 43, 3'b011, "w32 ror");
      model_op(32, 32'h9600_0096, 0,  3'b100, "w32 rol0");
      model_op(32, 32'h5A5A_5A5A, 7,  3'b110, "w32 rsvd");
      model_op(32, 32'h8000_0000, 32, 3'b001, "w32 srl32");
      model_op(32, 32'h0000_0001, 63, 3'b000, "w32 sll63");

      // Random requests on both widths.
      for (int i = 0; i < 25; i++) begin
         rd = $urandom;
         rs = int'($urandom_range(0, 15));
         rm = 3'($urandom_range(0, 7));
         model_op(8, rd & 32'hFF, rs, rm, "rand8");
      end
      for (int i = 0; i < 25; i++) begin
         rd = $urandom;
         rs = int'($urandom_range(0, 63));
         rm = 3'($urandom_range(0, 7));
         model_op(32, rd, rs, rm, "rand32");
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/multicycle_shift_unit.md
Name: multicycle_shift_unit

Overview:
- Parametrised, iterative barrel shifter for the ALU datapath of the next-generation processor.
- Supports logical left/right shift, arithmetic right shift, rotate right and rotate left on a WIDTH-bit operand.
- Resolves one binary stage of the shift amount per clock.
- Exchanges operands and results with the control unit over valid/ready handshakes, and produces carry-out and zero flags.

Parameters:
- WIDTH, 8, operand/result width; must be a power of two, >= 4.
- SHAMT_W, $clog2(WIDTH)+1, width of the shift-amount port; must not be overridden.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- IN_VALID  input  1  operand/amount/mode presented.
- IN_READY  output  1  unit can accept a request.
- DATA  input  WIDTH  value to shift.
- SHAMT  input  SHAMT_W  shift amount, unsigned.
- MODE  input  3  operation select: 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others reserved.
- OUT_VALID  output  1  result available.
- OUT_READY  input  1  consumer takes the result.
- RESULT  output  WIDTH  shifted value.
- CARRY  output  1  last bit shifted/rotated out.
- ZERO  output  1  RESULT == 0.

Behaviour:
- Clocking and reset: one clock, CLK; RESET is asynchronous and active-high.
- While RESET is asserted: state=IDLE; IN_READY=1; OUT_VALID=0; RESULT=0; CARRY=0; ZERO=0; stage counter=0.
- Reset mid-operation: the in-flight request is discarded and no result is ever presented for it.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - IN_READY=1.
  - Accept occurs on a rising edge with IN_VALID=1.
  - At acceptance, latch DATA, MODE and effective amount E; compute and latch CARRY; go to SHIFT with stage counter k=0.
  - DATA, SHAMT and MODE are sampled only at acceptance; later changes have no effect.
- SHIFT:
  - IN_READY=0.
  - Each edge applies stage k: if E[k]=1, shift/rotate the working register by 2^k in MODE's direction; fill is 0 for SLL/SRL, the latched sign bit for SRA, wrapped bits for rotates.
  - k increments each edge; after the stage with k=L-1 (L=log2(WIDTH)), go to DONE.
- DONE:
  - OUT_VALID=1 and ZERO=(RESULT==0).
  - RESULT/CARRY/ZERO are held stable while OUT_READY=0.
  - Transfer on an edge with OUT_VALID & OUT_READY, then go to IDLE.
  - IN_READY=0 in DONE; no overlap between requests.
- Latency: accept at edge t gives OUT_VALID high after edge t+L (WIDTH=8: 3 cycles). Minimum initiation interval is L+2 cycles.
- Effective amount E:
  - Rotates: E = SHAMT mod WIDTH.
  - Shifts with SHAMT < WIDTH: E = SHAMT.
  - Shifts with SHAMT >= WIDTH: the working register is forced at acceptance to 0 (SLL/SRL) or all copies of DATA[WIDTH-1] (SRA), and E=0.
  - The L stage cycles are still spent, so latency is constant.
- CARRY, computed from the latched DATA at acceptance, for n=SHAMT:
  - n=0: 0 for all modes.
  - SLL, 1<=n<=WIDTH: DATA[WIDTH-n]; n>WIDTH: 0.
  - SRL, 1<=n<=WIDTH: DATA[n-1]; n>WIDTH: 0.
  - SRA, 1<=n<=WIDTH: DATA[n-1]; n>WIDTH: DATA[WIDTH-1].
  - ROR with E!=0: final RESULT[WIDTH-1]; ROL with E!=0: final RESULT[0]; either rotate with E=0: 0.
- Reserved MODE: the request is accepted and completes with normal latency; RESULT=DATA, CARRY=0.
- OUT_READY high while not in DONE is ignored. IN_VALID outside IDLE is ignored and the request is not lost; the producer must hold it.

Test Plan:
1. WIDTH=8, SLL DATA=0x96 SHAMT=3 -> OUT_VALID exactly 3 cycles after acceptance; RESULT=0xB0, CARRY=0, ZERO=0.
2. SRA 0x96 SHAMT=2 -> RESULT=0xE5, CARRY=1; then SRA 0x96 SHAMT=9 -> RESULT=0xFF, CARRY=1.
3. ROR 0x96 SHAMT=11 -> RESULT=0xD2, CARRY=1; then ROL 0x96 SHAMT=0 -> RESULT=0x96, CARRY=0; then reserved MODE=111 DATA=0x5A -> RESULT=0x5A, CARRY=0.
4. SRL 0x80 SHAMT=8 -> RESULT=0x00, ZERO=1, CARRY=1; then SLL 0x01 SHAMT=15 -> RESULT=0x00, CARRY=0, latency still 3.
5. Hold OUT_READY=0 for 5 cycles in DONE while toggling DATA and asserting IN_VALID -> RESULT/CARRY/ZERO unchanged, IN_READY=0, no second acceptance; OUT_READY=1 -> one transfer, IN_READY=1 next cycle.
6. Assert RESET during SHIFT at k=1 -> OUT_VALID=0 and IN_READY=1 immediately without a clock edge. After release, SLL 0x01 SHAMT=1 -> RESULT=0x02 with no stale data. Repeat cases 1-4 with WIDTH=32 against a reference model.
